// File: rtl/rs_kes_bm_16_8.sv
// rs_kes_bm_16_8: inversionless Berlekamp-Massey key-equation solver, RS(16,8), GF(256)/0x11d, t=4.
// Optional macro RS_KES_ZERO_BYPASS_EN: all-zero syndrome frames skip the iterations.

module gf256mul_dec (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] aa;

    // shift-and-add product, reduced by x^8 = x^4+x^3+x^2+1
    always_comb begin
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
        end
    end
endmodule

module rs_kes_bm_16_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syndrome_val,
    input  logic [63:0] syndrome,
    output logic        kes_busy,
    output logic        kes_val,
    output logic [39:0] sigma,
    output logic [31:0] omega,
    output logic [3:0]  err_deg,
    output logic        no_err,
    output logic        kes_fail
);
    localparam int R_NUM = 8;
    localparam int T     = 4;

    typedef enum logic [1:0] {IDLE, CALC, OMEGA} state_t;

    state_t     state;
    logic [7:0] s       [R_NUM];
    logic [7:0] sig     [9];
    logic [7:0] bb      [9];
    logic [7:0] gamma;
    logic [3:0] len;
    logic [2:0] r;

    logic [7:0] s_term  [9];
    logic [7:0] xb      [9];
    logic [7:0] d_prod  [9];
    logic [7:0] g_sig   [9];
    logic [7:0] d_xb    [9];
    logic [7:0] om_prod [10];
    logic [7:0] om      [T];
    logic [7:0] delta;
    logic [7:0] s_or;
    logic [3:0] idx;
    logic [3:0] deg;
    logic       s_zero;
    logic       upd;
    logic       bypass;

    // syndrome taps S(r-i) for the discrepancy, and x*B
    always_comb begin
        xb[0] = 8'h00;
        for (int i = 1; i < 9; i++) xb[i] = bb[i - 1];
        idx = 4'd0;
        for (int i = 0; i < 9; i++) begin
            idx       = {1'b0, r} - 4'(i);
            s_term[i] = idx[3] ? 8'h00 : s[idx[2:0]];
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_mul
        gf256mul_dec u_d (.a(sig[i]), .b(s_term[i]), .p(d_prod[i]));
        gf256mul_dec u_g (.a(gamma),  .b(sig[i]),    .p(g_sig[i]));
        gf256mul_dec u_b (.a(delta),  .b(xb[i]),     .p(d_xb[i]));
    end

    for (genvar k = 0; k < T; k++) begin : g_omk
        for (genvar i = 0; i <= k; i++) begin : g_omi
            gf256mul_dec u_o (
                .a(sig[i]),
                .b(s[k - i]),
                .p(om_prod[k * (k + 1) / 2 + i])
            );
        end
    end

    // discrepancy, evaluator, locator degree and zero-syndrome detect
    always_comb begin
        delta = 8'h00;
        for (int i = 0; i < 9; i++) delta = delta ^ d_prod[i];
        for (int k = 0; k < T; k++) begin
            om[k] = 8'h00;
            for (int i = 0; i <= k; i++) om[k] = om[k] ^ om_prod[k * (k + 1) / 2 + i];
        end
        deg = 4'd0;
        for (int i = 0; i < 9; i++) if (sig[i] != 8'h00) deg = 4'(i);
        s_or = 8'h00;
        for (int i = 0; i < R_NUM; i++) s_or = s_or | s[i];
        s_zero = (s_or == 8'h00);
        upd    = (delta != 8'h00) && ({len, 1'b0} <= {2'b00, r});
    end

`ifdef RS_KES_ZERO_BYPASS_EN
    assign bypass = s_zero;
`else
    assign bypass = 1'b0;
`endif

    // control FSM, BM iteration registers and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            kes_busy <= 1'b0;
            kes_val  <= 1'b0;
            sigma    <= '0;
            omega    <= '0;
            err_deg  <= '0;
            no_err   <= 1'b0;
            kes_fail <= 1'b0;
            gamma    <= '0;
            len      <= '0;
            r        <= '0;
            for (int i = 0; i < R_NUM; i++) s[i] <= '0;
            for (int i = 0; i < 9; i++) begin
                sig[i] <= '0;
                bb[i]  <= '0;
            end
        end else begin
            kes_val <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (syndrome_val) begin
                        for (int i = 0; i < R_NUM; i++) s[i] <= syndrome[8*i +: 8];
                        for (int i = 0; i < 9; i++) begin
                            sig[i] <= (i == 0) ? 8'h01 : 8'h00;
                            bb[i]  <= (i == 0) ? 8'h01 : 8'h00;
                        end
                        gamma    <= 8'h01;
                        len      <= 4'd0;
                        r        <= 3'd0;
                        kes_busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (bypass) begin
                        state <= OMEGA;
                    end else begin
                        for (int i = 0; i < 9; i++) sig[i] <= g_sig[i] ^ d_xb[i];
                        if (upd) begin
                            for (int i = 0; i < 9; i++) bb[i] <= sig[i];
                            len   <= {1'b0, r} + 4'd1 - len;
                            gamma <= delta;
                        end else begin
                            for (int i = 0; i < 9; i++) bb[i] <= xb[i];
                        end
                        r <= r + 3'd1;
                        if (r == 3'd7) state <= OMEGA;
                    end
                end
                OMEGA: begin
                    sigma    <= {sig[4], sig[3], sig[2], sig[1], sig[0]};
                    omega    <= {om[3], om[2], om[1], om[0]};
                    err_deg  <= len;
                    no_err   <= s_zero;
                    kes_fail <= (len > 4'd4) || (deg != len);
                    kes_val  <= 1'b1;
                    kes_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_kes_bm_16_8.sv
// tb_rs_kes_bm_16_8: random error patterns checked against a GF(256) locator/evaluator model.
// Also covers directed frames, ignored pulses, and mid-frame reset.

module tb_rs_kes_bm_16_8;
`ifdef RS_KES_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syndrome_val = 1'b0;
    logic [63:0] syndrome = '0;
    logic        kes_busy;
    logic        kes_val;
    logic [39:0] sigma;
    logic [31:0] omega;
    logic [3:0]  err_deg;
    logic        no_err;
    logic        kes_fail;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] exp_t [0:255];
    logic [7:0] log_t [0:255];
    logic [7:0] ev    [16];

    always #5 clk = ~clk;

    rs_kes_bm_16_8 dut (
        .clk(clk),
        .rst_n(rst_n),
        .syndrome_val(syndrome_val),
        .syndrome(syndrome),
        .kes_busy(kes_busy),
        .kes_val(kes_val),
        .sigma(sigma),
        .omega(omega),
        .err_deg(err_deg),
        .no_err(no_err),
        .kes_fail(kes_fail)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        return exp_t[(255 - int'(log_t[a])) % 255];
    endfunction

    // syndromes, normalised locator prod(1+X x) and S*lambda mod x^4 from ev[]
    task automatic model(output logic [63:0] syn, output logic [39:0] lam_p, output logic [31:0] om_p);
        logic [7:0] s [8];
        logic [7:0] lam [9];
        logic [7:0] acc;
        for (int i = 0; i < 8; i++) begin
            s[i] = 8'h00;
            for (int j = 0; j < 16; j++)
                s[i] = s[i] ^ gmul(ev[j], exp_t[(j * (i + 1)) % 255]);
            syn[8*i +: 8] = s[i];
        end
        for (int d = 0; d < 9; d++) lam[d] = (d == 0) ? 8'h01 : 8'h00;
        for (int j = 0; j < 16; j++)
            if (ev[j] != 8'h00)
                for (int d = 8; d >= 1; d--) lam[d] = lam[d] ^ gmul(exp_t[j], lam[d - 1]);
        for (int d = 0; d < 5; d++) lam_p[8*d +: 8] = lam[d];
        for (int k = 0; k < 4; k++) begin
            acc = 8'h00;
            for (int i = 0; i <= k; i++) acc = acc ^ gmul(lam[i], s[k - i]);
            om_p[8*k +: 8] = acc;
        end
    endtask

    // one frame: pulse at edge N, count edges to kes_val, optional stray pulses
    task automatic run_frame(input logic [63:0] syn, input bit extra, output int lat);
        int k;
        int drops;
        int more;
        @(negedge clk);
        syndrome     = syn;
        syndrome_val = 1'b1;
        @(negedge clk);
        syndrome_val = 1'b0;
        syndrome     = {$urandom, $urandom};
        check("busy_rise", kes_busy, 1);
        k = 0;
        drops = 0;
        while (!kes_val && k < 40) begin
            if (!kes_busy) drops++;
            syndrome_val = extra && (k == 3 || k == 8);
            @(negedge clk);
            k++;
        end
        syndrome_val = 1'b0;
        lat = k;
        check("busy_held", drops, 0);
        check("busy_fall", kes_busy, 0);
        more = 0;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            if (kes_val) more++;
        end
        check("one_val", more, 0);
    endtask

    function automatic logic [39:0] norm_sig(input logic [39:0] v);
        logic [7:0] inv;
        inv = ginv(v[7:0]);
        for (int i = 0; i < 5; i++) norm_sig[8*i +: 8] = gmul(v[8*i +: 8], inv);
    endfunction

    function automatic logic [31:0] norm_om(input logic [31:0] v, input logic [7:0] s0);
        logic [7:0] inv;
        inv = ginv(s0);
        for (int i = 0; i < 4; i++) norm_om[8*i +: 8] = gmul(v[8*i +: 8], inv);
    endfunction

    function automatic logic [7:0] eval_sig(input logic [39:0] v, input int e);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 5; i++) acc = acc ^ gmul(v[8*i +: 8], exp_t[(i * e) % 255]);
        return acc;
    endfunction

    initial begin
        int x;
        int lat;
        int v;
        int cnt;
        int p;
        int vals;
        logic [63:0] syn;
        logic [39:0] lam_p;
        logic [31:0] om_p;

        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = 8'(x);
            log_t[x] = 8'(i);
            x = x << 1;
            if (x > 255) x = x ^ 'h11d;
        end
        exp_t[255] = exp_t[0];
        log_t[0]   = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_sigma", sigma, 0);
        check("rst_omega", omega, 0);
        check("rst_flags", {kes_busy, kes_val, err_deg, no_err, kes_fail}, 0);
        rst_n = 1'b1;

        // single error 01 at alpha
        for (int j = 0; j < 16; j++) ev[j] = 8'h00;
        ev[1] = 8'h01;
        model(syn, lam_p, om_p);
        check("se_syn", syn, 64'h1d80_4020_1008_0402);
        run_frame(syn, 1'b0, lat);
        check("se_lat", lat, 9);
        check("se_sigma", sigma, 40'h00_0000_1d80);
        check("se_omega", omega, 32'h0000_001d);
        check("se_flags", {err_deg, no_err, kes_fail}, {4'd1, 1'b0, 1'b0});

        // all-zero syndromes
        run_frame(64'h0, 1'b0, lat);
        check("zero_lat", lat, BYP ? 2 : 9);
        check("zero_sigma", sigma, 40'h01);
        check("zero_omega", omega, 0);
        check("zero_flags", {err_deg, no_err, kes_fail}, {4'd0, 1'b1, 1'b0});

        // only S7 nonzero: L=8, uncorrectable
        run_frame(64'h0100_0000_0000_0000, 1'b1, lat);
        check("s7_lat", lat, 9);
        check("s7_sigma", sigma, 40'h01);
        check("s7_omega", omega, 0);
        check("s7_flags", {err_deg, no_err, kes_fail}, {4'd8, 1'b0, 1'b1});

        // two errors 05 at alpha^3, 9c at alpha^10
        for (int j = 0; j < 16; j++) ev[j] = 8'h00;
        ev[3]  = 8'h05;
        ev[10] = 8'h9c;
        model(syn, lam_p, om_p);
        run_frame(syn, 1'b1, lat);
        check("te_lat", lat, 9);
        check("te_deg", err_deg, 2);
        check("te_fail", kes_fail, 0);
        check("te_sigma", norm_sig(sigma), lam_p);
        check("te_omega", norm_om(omega, sigma[7:0]), om_p);
        check("te_root3", eval_sig(sigma, 255 - 3), 0);
        check("te_root10", eval_sig(sigma, 255 - 10), 0);

        // random patterns of 0..4 errors
        for (int f = 0; f < 30; f++) begin
            for (int j = 0; j < 16; j++) ev[j] = 8'h00;
            v = $urandom_range(0, 4);
            cnt = 0;
            while (cnt < v) begin
                p = $urandom_range(0, 15);
                if (ev[p] == 8'h00) begin
                    vals = $urandom_range(1, 255);
                    ev[p] = 8'(vals);
                    cnt++;
                end
            end
            model(syn, lam_p, om_p);
            run_frame(syn, f[0], lat);
            check("rnd_lat", lat, (v == 0 && BYP) ? 2 : 9);
            check("rnd_sig0_nz", sigma[7:0] != 8'h00, 1);
            check("rnd_sigma", norm_sig(sigma), lam_p);
            check("rnd_omega", norm_om(omega, sigma[7:0]), om_p);
            check("rnd_flags", {err_deg, no_err, kes_fail}, {4'(v), v == 0, 1'b0});
        end

        // reset mid-frame aborts it
        for (int j = 0; j < 16; j++) ev[j] = 8'h00;
        ev[5] = 8'h37;
        model(syn, lam_p, om_p);
        @(negedge clk);
        syndrome     = syn;
        syndrome_val = 1'b1;
        @(negedge clk);
        syndrome_val = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ab_sigma", sigma, 0);
        check("ab_omega", omega, 0);
        check("ab_flags", {kes_busy, kes_val, err_deg, no_err, kes_fail}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (kes_val) cnt++;
        end
        check("ab_no_val", cnt, 0);
        run_frame(syn, 1'b0, lat);
        check("ab_lat", lat, 9);
        check("ab_sigma2", norm_sig(sigma), lam_p);
        check("ab_omega2", norm_om(omega, sigma[7:0]), om_p);
        check("ab_flags2", {err_deg, no_err, kes_fail}, {4'd1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
